node_lookup_arbiter: RTL and testbench

// - Shares the single node-tree lookup engine among NUM_REQ field-id requesters (per-stream decoders).
// - The engine searches without pipelining, so this block keeps exactly one lookup in flight.
// - Round-robin grant; the returned node_data goes back to the granted requester only.
// - Sits between the decoder front-ends and the node tree; owns the tree's field_id/node handshakes.

---
 rtl/node_arb_pkg.sv | 21 ++
 rtl/node_lookup_arbiter_rr_pick.sv | 30 +++
 rtl/node_lookup_arbiter.sv | 120 ++++++++++++
 tb/tb_node_lookup_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_arb_pkg.sv
// node_arb_pkg: shared types, state codes and limits for node_lookup_arbiter.
// identifier / node_data mirror the node-tree interface types.
package node_arb_pkg;

  typedef logic [7:0]  identifier;
  typedef logic [31:0] node_data;
  localparam node_data null_node_data = '0;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int TIMEOUT_W          = 8;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_idx_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t ISSUE  = 2'd1;
  localparam arb_state_t WAIT   = 2'd2;
  localparam arb_state_t RETURN = 2'd3;

endpackage

// File: rtl/node_lookup_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Picks the first set bit of valid at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!any && valid[IDX_W'(cand)]) begin
        any = 1'b1;
        idx = IDX_W'(cand);
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/node_lookup_arbiter.sv
// node_lookup_arbiter: round-robin sharing of the non-pipelined node-tree lookup engine.
// Define NODE_ARB_TIMEOUT_EN to bound the WAIT state with a TIMEOUT_CYCLES watchdog.
module node_lookup_arbiter
  import node_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  identifier [NUM_REQ-1:0]   req_field_id_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_rdy_o,
  output node_data                  rsp_node_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_rdy_i,
  output logic                      rsp_err_o,
  output identifier                 field_id_o,
  output logic                      field_id_valid_o,
  input  logic                      field_id_rdy_i,
  input  node_data                  node_i,
  input  logic                      node_valid_i,
  output logic                      node_rdy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic             pick_any;
  identifier        fid_q;
  node_data         node_q;
  logic             timed_out;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .valid (req_valid_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef NODE_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 err_q;

  // A real node arriving on the expiry cycle takes precedence over the timeout.
  assign timed_out = (state == WAIT) && !node_valid_i &&
                     (wait_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
      if (state == WAIT && node_valid_i) err_q <= 1'b0;
      else if (timed_out)                 err_q <= 1'b1;
    end
  end

  assign rsp_err_o = err_q && (state == RETURN);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != TIMEOUT_W);
  assign timed_out      = 1'b0;
  assign rsp_err_o      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_idx <= '0;
      fid_q   <= '0;
      node_q  <= null_node_data;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          gnt_idx <= pick_idx;
          fid_q   <= req_field_id_i[pick_idx];
          state   <= ISSUE;
        end
        ISSUE: if (field_id_rdy_i) state <= WAIT;
        WAIT: begin
          if (node_valid_i) begin
            node_q <= node_i;
            state  <= RETURN;
          end else if (timed_out) begin
            node_q <= null_node_data;
            state  <= RETURN;
          end
        end
        RETURN: if (rsp_rdy_i[gnt_idx]) begin
          rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The accept pulse is combinational, so it is gated to stay low while reset is held.
  always_comb begin
    req_rdy_o   = '0;
    rsp_valid_o = '0;
    if (reset_i && state == IDLE) req_rdy_o = pick_grant;
    if (state == RETURN) rsp_valid_o[gnt_idx] = 1'b1;
  end

  assign field_id_o       = fid_q;
  assign field_id_valid_o = (state == ISSUE);
  assign node_rdy_o       = (state == WAIT);
  assign rsp_node_o       = node_q;

endmodule

// File: tb/tb_node_lookup_arbiter.sv
// Testbench for node_lookup_arbiter: table-driven lookups, hand sequences and random traffic
// checked against a round-robin model; watchdog checks build with NODE_ARB_TIMEOUT_EN.
module tb_node_lookup_arbiter;
  import node_arb_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  identifier [N-1:0] req_field_id;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_rdy;
  node_data         rsp_node;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_rdy;
  logic             rsp_err;
  identifier        field_id;
  logic             field_id_valid;
  logic             field_id_rdy;
  node_data         node_in;
  logic             node_valid;
  logic             node_rdy;

  int vectors     = 0;
  int miscompares = 0;
  int model_ptr   = 0;

  typedef struct {
    logic [N-1:0] mask;
    int           exp_g;
    node_data     node;
    int           issue_stall;
    int           tree_lat;
    int           rsp_stall;
    bit           stray;
  } vec_t;

  vec_t vec_tab [10];

  always #5 clk = ~clk;

  node_lookup_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk_i            (clk),
    .reset_i          (reset_n),
    .req_field_id_i   (req_field_id),
    .req_valid_i      (req_valid),
    .req_rdy_o        (req_rdy),
    .rsp_node_o       (rsp_node),
    .rsp_valid_o      (rsp_valid),
    .rsp_rdy_i        (rsp_rdy),
    .rsp_err_o        (rsp_err),
    .field_id_o       (field_id),
    .field_id_valid_o (field_id_valid),
    .field_id_rdy_i   (field_id_rdy),
    .node_i           (node_in),
    .node_valid_i     (node_valid),
    .node_rdy_o       (node_rdy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: first requesting index at or after the pointer, wrapping.
  function automatic int modelPick(input logic [N-1:0] mask);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (model_ptr + k) % N;
      if (mask[c[1:0]]) return c;
    end
    return 0;
  endfunction

  // One complete lookup with optional stalls and a stray tree pulse.
  task automatic applyStimulus(input logic [N-1:0] mask, input int exp_g, input node_data node_val,
                               input int issue_stall, input int tree_lat, input int rsp_stall,
                               input bit stray);
    identifier    ids [N];
    identifier    exp_id;
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[exp_g[1:0]] = 1'b1;
    if (stray) begin
      node_valid = 1'b1;
      node_in    = 32'hDEAD_BEEF;
      #1 checkOutput("stray_idle_node_rdy", 32'(node_rdy), 32'd0);
      tick();
      node_valid = 1'b0;
      checkOutput("stray_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    for (int i = 0; i < N; i++) ids[i] = identifier'($urandom);
    req_field_id = {ids[3], ids[2], ids[1], ids[0]};
    exp_id       = ids[exp_g];
    req_valid    = mask;
    #1 checkOutput("grant", 32'(req_rdy), 32'(onehot));
    tick();
    req_valid[exp_g[1:0]]    = 1'b0;
    req_field_id[exp_g[1:0]] = ~exp_id;
    #1;
    checkOutput("issue_req_rdy", 32'(req_rdy), 32'd0);
    checkOutput("issue_valid", 32'(field_id_valid), 32'd1);
    checkOutput("issue_field_id", 32'(field_id), 32'(exp_id));
    for (int s = 0; s < issue_stall; s++) begin
      if (s == 0 && stray) begin
        node_valid = 1'b1;
        node_in    = 32'hBAD0_0000;
      end
      tick();
      node_valid = 1'b0;
      checkOutput("issue_hold_valid", 32'(field_id_valid), 32'd1);
      checkOutput("issue_hold_field_id", 32'(field_id), 32'(exp_id));
      checkOutput("issue_hold_node_rdy", 32'(node_rdy), 32'd0);
      checkOutput("issue_hold_req_rdy", 32'(req_rdy), 32'd0);
    end
    field_id_rdy = 1'b1;
    tick();
    field_id_rdy = 1'b0;
    checkOutput("wait_node_rdy", 32'(node_rdy), 32'd1);
    checkOutput("wait_field_id_valid", 32'(field_id_valid), 32'd0);
    for (int s = 1; s < tree_lat; s++) begin
      tick();
      checkOutput("wait_hold_node_rdy", 32'(node_rdy), 32'd1);
    end
    node_valid = 1'b1;
    node_in    = node_val;
    tick();
    node_valid = 1'b0;
    node_in    = $urandom;
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(onehot));
    checkOutput("rsp_node", rsp_node, node_val);
    checkOutput("rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("return_node_rdy", 32'(node_rdy), 32'd0);
    for (int s = 0; s < rsp_stall; s++) begin
      rsp_rdy = ~onehot;
      tick();
      checkOutput("rsp_hold_valid", 32'(rsp_valid), 32'(onehot));
      checkOutput("rsp_hold_node", rsp_node, node_val);
      checkOutput("rsp_hold_req_rdy", 32'(req_rdy), 32'd0);
    end
    rsp_rdy = onehot;
    tick();
    rsp_rdy = '0;
    checkOutput("rsp_done_valid", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    model_ptr = (exp_g + 1) % N;
  endtask

`ifdef NODE_ARB_TIMEOUT_EN
  task automatic timeoutRun(input bit answer_last);
    logic [N-1:0] onehot;
    int           g;
    g = modelPick(4'b0001);
    onehot = '0;
    onehot[g[1:0]] = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid    = '0;
    field_id_rdy = 1'b1;
    tick();
    field_id_rdy = 1'b0;
    repeat (15) tick();
    checkOutput("to_cycle16_node_rdy", 32'(node_rdy), 32'd1);
    if (answer_last) begin
      node_valid = 1'b1;
      node_in    = 32'h1234_5678;
    end
    tick();
    node_valid = 1'b0;
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'(onehot));
    checkOutput("to_rsp_node", rsp_node, answer_last ? 32'h1234_5678 : null_node_data);
    checkOutput("to_rsp_err", 32'(rsp_err), answer_last ? 32'd0 : 32'd1);
    rsp_rdy = onehot;
    tick();
    rsp_rdy = '0;
    model_ptr = (g + 1) % N;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] mask;
    int           g;

    vec_tab[0] = '{4'b0100, 2, 32'hC0DE_0005, 0, 2, 0, 1'b0};
    vec_tab[1] = '{4'b1010, 3, 32'hC0DE_0101, 5, 1, 4, 1'b0};
    vec_tab[2] = '{4'b1010, 1, 32'hC0DE_0202, 0, 3, 0, 1'b0};
    vec_tab[3] = '{4'b1111, 2, 32'hC0DE_0303, 1, 1, 1, 1'b1};
    vec_tab[4] = '{4'b1111, 3, 32'hC0DE_0404, 0, 1, 0, 1'b0};
    vec_tab[5] = '{4'b1111, 0, 32'hC0DE_0505, 2, 2, 0, 1'b0};
    vec_tab[6] = '{4'b0001, 0, null_node_data, 0, 1, 0, 1'b0};
    vec_tab[7] = '{4'b1001, 3, 32'hC0DE_0707, 0, 4, 2, 1'b1};
    vec_tab[8] = '{4'b0110, 1, 32'hC0DE_0808, 1, 1, 0, 1'b0};
    vec_tab[9] = '{4'b0011, 0, 32'hC0DE_0909, 0, 2, 1, 1'b0};

    reset_n      = 1'b0;
    req_valid    = 4'b1111;
    req_field_id = '0;
    rsp_rdy      = '0;
    field_id_rdy = 1'b0;
    node_in      = '0;
    node_valid   = 1'b0;
    repeat (2) tick();
    checkOutput("reset_req_rdy", 32'(req_rdy), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_field_id_valid", 32'(field_id_valid), 32'd0);
    checkOutput("reset_field_id", 32'(field_id), 32'd0);
    checkOutput("reset_node_rdy", 32'(node_rdy), 32'd0);
    checkOutput("reset_rsp_node", rsp_node, null_node_data);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    req_valid = '0;
    reset_n   = 1'b1;
    tick();

    foreach (vec_tab[i])
      applyStimulus(vec_tab[i].mask, vec_tab[i].exp_g, vec_tab[i].node, vec_tab[i].issue_stall,
                    vec_tab[i].tree_lat, vec_tab[i].rsp_stall, vec_tab[i].stray);

    // Reset while a lookup is parked in WAIT.
    req_valid = 4'b1000;
    tick();
    req_valid    = '0;
    field_id_rdy = 1'b1;
    tick();
    field_id_rdy = 1'b0;
    checkOutput("midwait_node_rdy", 32'(node_rdy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midwait_reset_node_rdy", 32'(node_rdy), 32'd0);
    checkOutput("midwait_reset_field_id", 32'(field_id), 32'd0);
    checkOutput("midwait_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midwait_reset_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    model_ptr = 0;
    tick();

    for (int i = 0; i < 5; i++)
      applyStimulus(4'b1111, i % N, 32'hA11_0000 + 32'(i), 0, 1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      mask = 4'($urandom_range(1, 15));
      g    = modelPick(mask);
      applyStimulus(mask, g, $urandom, $urandom_range(0, 3), $urandom_range(1, 4),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

`ifdef NODE_ARB_TIMEOUT_EN
    timeoutRun(1'b0);
    timeoutRun(1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
